// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
//   mem_state_t    : stage FSM states (IDLE, BUS, DONE)
//   mem_size_t     : access width decoded from the instruction
//   instructions_t : one-hot decode flags from the decoder
//   regvpair_t     : register operands (rs2 carries store data)
//   EXC_*          : trap cause codes reported on exc_cause
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        DONE
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_t;

    typedef struct packed {
        logic lb;
        logic lh;
        logic lw;
        logic lbu;
        logic lhu;
        logic sb;
        logic sh;
        logic sw;
        logic add;
        logic sub;
        logic other;
    } instructions_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
    } regvpair_t;

    localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
    localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
    localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
    localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

    function automatic logic is_load(input instructions_t i);
        return i.lb | i.lh | i.lw | i.lbu | i.lhu;
    endfunction

    function automatic logic is_store(input instructions_t i);
        return i.sb | i.sh | i.sw;
    endfunction

    function automatic logic is_unsigned_load(input instructions_t i);
        return i.lbu | i.lhu;
    endfunction

    function automatic mem_size_t access_size(input instructions_t i);
        if (i.lb | i.lbu | i.sb) return SZ_BYTE;
        if (i.lh | i.lhu | i.sh) return SZ_HALF;
        return SZ_WORD;
    endfunction

    function automatic logic is_misaligned(input mem_size_t s, input logic [1:0] a);
        case (s)
            SZ_HALF: return a[0];
            SZ_WORD: return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment, shared with the core's AMO path.
//   rdata       : 32-bit word returned by the bus
//   addr_lo     : byte offset of the access inside the word
//   size        : access width
//   is_unsigned : 1 = zero-extend, 0 = sign-extend (ignored for words)
//   value       : selected lane, extended to 32 bits
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sign_bit;

    // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        byte_lane = rdata[7:0];
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        value     = rdata;
        sign_bit  = 1'b0;

        case (addr_lo)
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            2'd3:    byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase

        case (size)
            SZ_BYTE: begin
                sign_bit = byte_lane[7] & ~is_unsigned;
                value    = {{24{sign_bit}}, byte_lane};
            end
            SZ_HALF: begin
                sign_bit = half_lane[15] & ~is_unsigned;
                value    = {{16{sign_bit}}, half_lane};
            end
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage downstream of the execute ALU.
// Ports:
//   clk, rstn        : clock, synchronous active-low reset
//   enabled          : 1-cycle start pulse; instr/register/alu_result valid with it
//   instr, register  : decode flags and operands (rs2 = store data)
//   alu_result       : effective address for loads/stores, rd value otherwise
//   completed        : 1-cycle pulse, result/exc_* valid
//   result           : rd write value (load data, 0 for stores, alu_result otherwise)
//   exc_valid/cause/tval : exception flag, cause code and faulting address
//   mem_*            : single-beat valid/ready bus (word address, lane-replicated data, byte strobes)
// TIMEOUT_CYCLES bounds how long mem_valid may stay up before an access fault; 0 disables it.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enabled,
    input  instructions_t instr,
    input  regvpair_t     register,
    input  logic [31:0]   alu_result,
    output logic          completed,
    output logic [31:0]   result,
    output logic          exc_valid,
    output logic [3:0]    exc_cause,
    output logic [31:0]   exc_tval,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic [31:0]   mem_rdata
);

    mem_state_t  state_q, state_d;

    // Request registers kept for the duration of the bus access.
    logic [1:0]  req_lo;
    mem_size_t   req_size;
    logic        req_unsigned;
    logic [31:0] tmo_cnt;

    // Decode of the incoming instruction.
    logic        in_load, in_store, in_mem, in_misaligned;
    mem_size_t   in_size;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;

    // FSM strobes.
    logic        take_req, finish_imm, bus_ok, bus_tmo, tmo_hit;
    logic [31:0] load_value;

    logic unused_inputs;
    assign unused_inputs = ^{register.rs1, instr.add, instr.sub, instr.other};

    always_comb begin
        in_load       = is_load(instr);
        in_store      = is_store(instr);
        in_mem        = in_load | in_store;
        in_size       = access_size(instr);
        in_misaligned = in_mem && is_misaligned(in_size, alu_result[1:0]);
        case (in_size)
            SZ_BYTE: begin
                st_wdata = {4{register.rs2[7:0]}};
                st_wstrb = 4'b0001 << alu_result[1:0];
            end
            SZ_HALF: begin
                st_wdata = {2{register.rs2[15:0]}};
                st_wstrb = 4'b0011 << alu_result[1:0];
            end
            default: begin
                st_wdata = register.rs2;
                st_wstrb = 4'b1111;
            end
        endcase
    end

    // Ready on the same edge as the timeout wins because it is tested first below.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        take_req   = 1'b0;
        finish_imm = 1'b0;
        bus_ok     = 1'b0;
        bus_tmo    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enabled) begin
                    if (in_mem && !in_misaligned) begin
                        take_req = 1'b1;
                        state_d  = BUS;
                    end else begin
                        finish_imm = 1'b1;
                    end
                end
            end
            BUS: begin
                if (mem_ready) begin
                    bus_ok  = 1'b1;
                    state_d = DONE;
                end else if (tmo_hit) begin
                    bus_tmo = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            completed    <= 1'b0;
            result       <= '0;
            exc_valid    <= 1'b0;
            exc_cause    <= '0;
            exc_tval     <= '0;
            mem_valid    <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            req_lo       <= '0;
            req_size     <= SZ_WORD;
            req_unsigned <= 1'b0;
            tmo_cnt      <= '0;
        end else begin
            // completed is set on the edge entering DONE (or the immediate path) and
            // falls again one cycle later, giving a single-cycle pulse.
            completed <= finish_imm | bus_ok | bus_tmo;
            exc_valid <= 1'b0;

            if (take_req) begin
                mem_valid    <= 1'b1;
                mem_we       <= in_store;
                mem_addr     <= {alu_result[31:2], 2'b00};
                mem_wdata    <= in_store ? st_wdata : 32'h0;
                mem_wstrb    <= in_store ? st_wstrb : 4'b0000;
                req_lo       <= alu_result[1:0];
                req_size     <= in_size;
                req_unsigned <= is_unsigned_load(instr);
                tmo_cnt      <= '0;
            end

            if (finish_imm) begin
                if (in_mem) begin
                    result    <= '0;
                    exc_valid <= 1'b1;
                    exc_cause <= in_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                    exc_tval  <= alu_result;
                end else begin
                    result <= alu_result;
                end
            end

            if (state_q == BUS) begin
                if (bus_ok || bus_tmo) begin
                    mem_valid <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'b0000;
                end else begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                end
                if (bus_ok) begin
                    result <= mem_we ? 32'h0 : load_value;
                end else if (bus_tmo) begin
                    result    <= '0;
                    exc_valid <= 1'b1;
                    exc_cause <= mem_we ? EXC_ST_FAULT : EXC_LD_FAULT;
                    exc_tval  <= {mem_addr[31:2], req_lo};
                end
            end
        end
    end

    mem_stage_load_align u_load_align (
        .rdata       (mem_rdata),
        .addr_lo     (req_lo),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .value       (load_value)
    );

endmodule
